// File: rtl/req_buf_rr_arbiter.sv
// Round-robin arbiter that drains NUM_REQ request buffers into one registered valid/ready stage.
// A lock bit on a head entry pins the grant to that master. Define ARB_STATS_EN to add per-master grant counters.
module req_buf_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 32,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NUM_REQ*DATA_W-1:0]   buf_data_i,
    input  logic [NUM_REQ-1:0]          buf_empty_i,
    input  logic [NUM_REQ-1:0]          buf_lock_i,
    output logic [NUM_REQ-1:0]          buf_pop_o,
    output logic                        m_valid_o,
    input  logic                        m_ready_i,
    output logic [DATA_W-1:0]           m_data_o,
    output logic [ID_W-1:0]             m_id_o,
`ifdef ARB_STATS_EN
    input  logic                        stats_clr_i,
    output logic [NUM_REQ*16-1:0]       grant_cnt_o,
`endif
    output logic                        locked_o
);

    typedef enum logic {ST_ARB, ST_LOCKED} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     lock_owner_q, lock_owner_d;
    logic                m_valid_q, m_valid_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [ID_W-1:0]     m_id_q, m_id_d;

    logic [DATA_W-1:0]   buf_data [NUM_REQ];
    logic                win_vld;
    logic [ID_W-1:0]     win_idx;
    logic [ID_W:0]       cand;
    logic                load;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign buf_data[gi] = buf_data_i[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Scan downwards from the farthest offset so the closest non-empty buffer to rr_ptr wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        if (state_q == ST_LOCKED) begin
            win_vld = ~buf_empty_i[lock_owner_q];
            win_idx = lock_owner_q;
        end else begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                cand = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
                if (cand >= (ID_W+1)'(NUM_REQ)) begin
                    cand = cand - (ID_W+1)'(NUM_REQ);
                end
                if (!buf_empty_i[cand[ID_W-1:0]]) begin
                    win_vld = 1'b1;
                    win_idx = cand[ID_W-1:0];
                end
            end
        end
    end

    assign load = resetn & win_vld & (~m_valid_q | m_ready_i);

    always_comb begin
        buf_pop_o = '0;
        if (load) begin
            buf_pop_o[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lock_owner_d = lock_owner_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_id_d       = m_id_q;
        if (load) begin
            m_valid_d = 1'b1;
            m_data_d  = buf_data[win_idx];
            m_id_d    = win_idx;
            rr_ptr_d  = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            if (buf_lock_i[win_idx]) begin
                state_d      = ST_LOCKED;
                lock_owner_d = win_idx;
            end else begin
                state_d = ST_ARB;
            end
        end else if (m_ready_i) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_ARB;
            rr_ptr_q     <= '0;
            lock_owner_q <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_id_q       <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_owner_q <= lock_owner_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_id_q       <= m_id_d;
        end
    end

    assign m_valid_o = m_valid_q;
    assign m_data_o  = m_data_q;
    assign m_id_o    = m_id_q;
    assign locked_o  = (state_q == ST_LOCKED);

`ifdef ARB_STATS_EN
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_stats
            logic [15:0] cnt_q, cnt_d;

            // Clear wins over a same-cycle grant; counters stick at all-ones.
            always_comb begin
                cnt_d = cnt_q;
                if (stats_clr_i) begin
                    cnt_d = '0;
                end else if (load && (win_idx == ID_W'(gi)) && (cnt_q != 16'hFFFF)) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign grant_cnt_o[gi*16 +: 16] = cnt_q;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_req_buf_rr_arbiter.sv
// Bench for req_buf_rr_arbiter: queue-modelled request buffers, a reference arbitration model
// and a scoreboard of popped entries compared against the output stage.
module tb_req_buf_rr_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [N*W-1:0] buf_data_i = '0;
    logic [N-1:0]   buf_empty_i = '1;
    logic [N-1:0]   buf_lock_i = '0;
    logic [N-1:0]   buf_pop_o;
    logic           m_valid_o;
    logic           m_ready_i = 1'b0;
    logic [W-1:0]   m_data_o;
    logic [IW-1:0]  m_id_o;
    logic           locked_o;
`ifdef ARB_STATS_EN
    logic            stats_clr_i = 1'b0;
    logic [N*16-1:0] grant_cnt_o;
`endif

    req_buf_rr_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .buf_data_i  (buf_data_i),
        .buf_empty_i (buf_empty_i),
        .buf_lock_i  (buf_lock_i),
        .buf_pop_o   (buf_pop_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_data_o    (m_data_o),
        .m_id_o      (m_id_o),
`ifdef ARB_STATS_EN
        .stats_clr_i (stats_clr_i),
        .grant_cnt_o (grant_cnt_o),
`endif
        .locked_o    (locked_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] d; logic l; } ent_t;
    typedef struct { logic [W-1:0] d; int id; } exp_t;

    ent_t bq [N][$];
    exp_t sb [$];

    int n_checks = 0;
    int n_errors = 0;
    bit mdl_lk, mdl_mv;
    int mdl_rr, mdl_owner;
    int grants0;
    bit quiet = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void push(input int k, input logic [W-1:0] d, input logic l);
        ent_t e;
        e.d = d;
        e.l = l;
        bq[k].push_back(e);
    endfunction

    // One clock: drive buffer heads, check DUT against the model, then advance both across the edge.
    task automatic tick();
        int          win;
        bit          load;
        logic [N-1:0] exp_pop;
        ent_t        e;
        exp_t        x;
        for (int k = 0; k < N; k++) begin
            if (bq[k].size() > 0) begin
                buf_empty_i[k]       = 1'b0;
                buf_data_i[k*W +: W] = bq[k][0].d;
                buf_lock_i[k]        = bq[k][0].l;
            end else begin
                buf_empty_i[k]       = 1'b1;
                buf_data_i[k*W +: W] = '0;
                buf_lock_i[k]        = 1'b0;
            end
        end
        #1;
        win = -1;
        if (mdl_lk) begin
            if (bq[mdl_owner].size() > 0) win = mdl_owner;
        end else begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (mdl_rr + i) % N;
                if (win < 0 && bq[k].size() > 0) win = k;
            end
        end
        load    = resetn && (win >= 0) && (!mdl_mv || m_ready_i);
        exp_pop = load ? (N'(1) << win) : '0;
        chk("pop", 64'(buf_pop_o), 64'(exp_pop));
        chk("valid", 64'(m_valid_o), 64'(mdl_mv));
        chk("locked", 64'(locked_o), 64'(mdl_lk));
        if (mdl_mv && sb.size() > 0) begin
            chk("data", 64'(m_data_o), 64'(sb[0].d));
            chk("id", 64'(m_id_o), 64'(sb[0].id));
        end
        @(posedge clk);
        if (!resetn) begin
            mdl_lk = 0; mdl_mv = 0; mdl_rr = 0; mdl_owner = 0;
            for (int k = 0; k < N; k++) bq[k].delete();
            sb.delete();
        end else begin
            if (mdl_mv && m_ready_i && sb.size() > 0) begin
                if (!quiet) $display("xfer id=%0d data=%08h", sb[0].id, sb[0].d);
                void'(sb.pop_front());
            end
            if (load) begin
                e    = bq[win].pop_front();
                x.d  = e.d;
                x.id = win;
                sb.push_back(x);
                mdl_mv = 1;
                mdl_rr = (win + 1) % N;
                if (e.l) begin
                    mdl_lk    = 1;
                    mdl_owner = win;
                end else begin
                    mdl_lk = 0;
                end
                if (win == 0) grants0++;
            end else if (m_ready_i) begin
                mdl_mv = 0;
            end
        end
        #1;
    endtask

    task automatic reset_dut();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic drain(input int max);
        int c;
        c = 0;
        while ((bq[0].size() + bq[1].size() + bq[2].size() + bq[3].size() + sb.size() > 0) && c < max) begin
            tick();
            c++;
        end
        chk("drain_left", 64'(bq[0].size() + bq[1].size() + bq[2].size() + bq[3].size() + sb.size()), 64'd0);
    endtask

    initial begin
        mdl_lk = 0; mdl_mv = 0; mdl_rr = 0; mdl_owner = 0; grants0 = 0;
        @(posedge clk);
        #1;
        reset_dut();
        chk("rst_valid", 64'(m_valid_o), 64'd0);
        chk("rst_data", 64'(m_data_o), 64'd0);
        chk("rst_id", 64'(m_id_o), 64'd0);
        chk("rst_locked", 64'(locked_o), 64'd0);
        chk("rst_pop", 64'(buf_pop_o), 64'd0);

        // Fair rotation across four full buffers.
        m_ready_i = 1'b1;
        for (int n = 0; n < 2; n++)
            for (int k = 0; k < N; k++)
                push(k, 32'h0A00_0000 + 32'(k << 8) + 32'(n), 1'b0);
        drain(20);

        // Single source with a stalled sink, then back-to-back drain.
        reset_dut();
        for (int n = 0; n < 3; n++) push(2, 32'hC200_0000 + 32'(n), 1'b0);
        m_ready_i = 1'b0;
        repeat (5) tick();
        chk("stall_data", 64'(m_data_o), 64'h0000_0000_C200_0000);
        chk("stall_left", 64'(bq[2].size()), 64'd2);
        m_ready_i = 1'b1;
        drain(20);

        // Locked sequence with a gap in the owner's buffer.
        reset_dut();
        push(1, 32'h5800_0001, 1'b1);
        push(1, 32'h5900_0001, 1'b1);
        tick();
        push(0, 32'h1000_0000, 1'b0);
        push(0, 32'h1000_0001, 1'b0);
        push(3, 32'h1300_0000, 1'b0);
        tick();
        repeat (3) tick();
        chk("lock_hold", 64'(locked_o), 64'd1);
        chk("lock_others_waiting", 64'(bq[0].size() + bq[3].size()), 64'd3);
        push(1, 32'h5A00_0001, 1'b0);
        drain(20);
        chk("unlock", 64'(locked_o), 64'd0);

        // Pointer wrap: grant 2 leaves rr_ptr at 3, then 3 then 0.
        reset_dut();
        push(2, 32'h4200_0000, 1'b0);
        tick();
        push(0, 32'h4000_0000, 1'b0);
        push(3, 32'h4300_0000, 1'b0);
        tick();
        chk("wrap_first", 64'(m_id_o), 64'd3);
        drain(20);

        // Reset while holding a locked entry.
        reset_dut();
        push(1, 32'h6100_0000, 1'b1);
        push(1, 32'h6100_0001, 1'b1);
        m_ready_i = 1'b0;
        tick();
        tick();
        chk("pre_rst_locked", 64'(locked_o), 64'd1);
        resetn = 1'b0;
        tick();
        chk("mid_rst_valid", 64'(m_valid_o), 64'd0);
        chk("mid_rst_locked", 64'(locked_o), 64'd0);
        chk("mid_rst_pop", 64'(buf_pop_o), 64'd0);
        resetn = 1'b1;
        m_ready_i = 1'b1;
        push(3, 32'h7300_0000, 1'b0);
        push(2, 32'h7200_0000, 1'b0);
        tick();
        chk("post_rst_first", 64'(m_id_o), 64'd2);
        drain(20);

`ifdef ARB_STATS_EN
        begin
            int c;
            reset_dut();
            quiet   = 1'b1;
            grants0 = 0;
            c       = 0;
            while (grants0 < 70000 && c < 80000) begin
                if (bq[0].size() == 0) push(0, 32'(c), 1'b0);
                tick();
                c++;
            end
            chk("stats_grants", 64'(grants0), 64'd70000);
            chk("stats_sat", 64'(grant_cnt_o[15:0]), 64'hFFFF);
            chk("stats_other", 64'(grant_cnt_o[16 +: 16]), 64'd0);
            stats_clr_i = 1'b1;
            if (bq[0].size() == 0) push(0, 32'hDEAD_0000, 1'b0);
            tick();
            stats_clr_i = 1'b0;
            chk("stats_clr", 64'(grant_cnt_o[15:0]), 64'd0);
            drain(20);
            quiet = 1'b0;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
